// File: rtl/serial_add_scheduler.sv
// serial_add_scheduler
// ---------------------------------------------------------------------------
// Sequencer and two-port round-robin arbiter in front of a single external
// combinational 1-bit full-adder cell. A granted requester's WIDTH-bit
// operand pair is streamed LSB-first through the cell, one bit per clock.
// An internal flop carries between bits. The (WIDTH+1)-bit result, tagged
// with the requester id, is returned on a valid/ready response port.
//
// Optional feature (compile-time macro SERIAL_SUB_EN):
//   Adds the req0_op/req1_op inputs (0 = add, 1 = subtract). When op is 1,
//   the B bits are inverted into the cell and the carry starts at 1, so the
//   result is A-B in two's complement. rsp_sum[WIDTH] = 1 means no borrow.
//
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous, active-low reset
//   reqN_valid / reqN_ready  requester N operand handshake (N = 0, 1)
//   reqN_a / reqN_b          requester N operands (WIDTH bits)
//   reqN_op                  requester N add/sub select (SERIAL_SUB_EN only)
//   fa_a / fa_b / fa_cin     bits driven into the full-adder cell
//   fa_s / fa_cout           sum and carry returned by the cell
//   rsp_valid / rsp_ready    result handshake
//   rsp_id                   requester that owns the result
//   rsp_sum                  {carry, sum}, WIDTH+1 bits
//   busy                     high whenever the sequencer is not idle
//   bit_cnt                  bit index being processed (0 outside ADD)
// ---------------------------------------------------------------------------
module serial_add_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [WIDTH-1:0]         req0_a,
    input  logic [WIDTH-1:0]         req0_b,
`ifdef SERIAL_SUB_EN
    input  logic                     req0_op,
`endif
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [WIDTH-1:0]         req1_a,
    input  logic [WIDTH-1:0]         req1_b,
`ifdef SERIAL_SUB_EN
    input  logic                     req1_op,
`endif
    output logic                     fa_a,
    output logic                     fa_b,
    output logic                     fa_cin,
    input  logic                     fa_s,
    input  logic                     fa_cout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [WIDTH:0]           rsp_sum,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam int SW = WIDTH - 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [SW-1:0]    sum_sh;
    logic             carry;
    logic             prio1;
    logic             grant1;
    logic             accept;
    logic             in_add;
    logic             sub_sel;

    // Round-robin choice: a lone requester always wins. When both are
    // valid, prio1 names the one that was not served last. prio1 resets to
    // 0, so req0 wins the first tie.
    always_comb begin
        grant1 = req1_valid;
        if (req0_valid && req1_valid) begin
            grant1 = prio1;
        end
    end

    // Ready is held low while reset is asserted, even though the state is
    // already IDLE, so that no operand can be accepted during reset.
    assign req0_ready = reset && (state == S_IDLE) && req0_valid && !grant1;
    assign req1_ready = reset && (state == S_IDLE) && req1_valid &&  grant1;
    assign accept     = req0_ready || req1_ready;

    assign in_add = (state == S_ADD);
    assign busy   = (state != S_IDLE);

`ifdef SERIAL_SUB_EN
    logic op_sub;
    assign sub_sel = grant1 ? req1_op : req0_op;
`else
    logic op_sub;
    assign sub_sel = 1'b0;
`endif

    // The cell inputs are driven only during ADD. Subtraction inverts the
    // B bits, and the carry flop was preloaded with 1 at accept.
    assign fa_a   = in_add & a_sh[0];
    assign fa_b   = in_add & (b_sh[0] ^ op_sub);
    assign fa_cin = in_add & carry;

    // Main sequencer. Sum bits enter sum_sh at the MSB end, so the last
    // sum bit and the final carry can be joined directly into rsp_sum on
    // the closing ADD edge. This gives a response WIDTH clocks after accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            op_sub    <= 1'b0;
            bit_cnt   <= '0;
            prio1     <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_sh    <= grant1 ? req1_a : req0_a;
                        b_sh    <= grant1 ? req1_b : req0_b;
                        op_sub  <= sub_sel;
                        carry   <= sub_sel;
                        bit_cnt <= '0;
                        rsp_id  <= grant1;
                        prio1   <= !grant1;
                        state   <= S_ADD;
                    end
                end
                S_ADD: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= (sum_sh >> 1) | (SW'(fa_s) << (SW - 1));
                    carry  <= fa_cout;
                    if (bit_cnt == LAST_BIT) begin
                        rsp_sum   <= {fa_cout, fa_s, sum_sh};
                        rsp_valid <= 1'b1;
                        bit_cnt   <= '0;
                        state     <= S_DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// tb_serial_add_scheduler
// ---------------------------------------------------------------------------
// Self-checking bench for serial_add_scheduler (WIDTH = 4). The external
// full-adder cell is modelled with plain logic. Expected results come from
// integer arithmetic on the operands. Expected grants come from a
// last-served round-robin rule kept in the bench.
// Define SERIAL_SUB_EN to exercise the subtract option as well.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_add_scheduler;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH);

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_op, req1_op;
    logic             fa_a, fa_b, fa_cin, fa_s, fa_cout;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH:0]   rsp_sum;
    logic             busy;
    logic [CW-1:0]    bit_cnt;

    int               total = 0;
    int               bad = 0;
    int               lastServed = 1;
    logic [WIDTH-1:0] heldA [2];
    logic [WIDTH-1:0] heldB [2];
    logic             heldOp [2];

    always #5 clk = ~clk;

    // Behavioural full-adder cell shared by the scheduler
    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    serial_add_scheduler #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
`ifdef SERIAL_SUB_EN
        .req0_op    (req0_op),
`endif
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
`ifdef SERIAL_SUB_EN
        .req1_op    (req1_op),
`endif
        .fa_a       (fa_a),
        .fa_b       (fa_b),
        .fa_cin     (fa_cin),
        .fa_s       (fa_s),
        .fa_cout    (fa_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .busy       (busy),
        .bit_cnt    (bit_cnt)
    );

    // Reference result: plain integer add, or A + ~B + 1 for subtract
    function automatic logic [WIDTH:0] refResult(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic sub);
        logic [WIDTH:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        else     r = {1'b0, a} + {1'b0, b};
        return r;
    endfunction

    // Reference arbitration: a lone requester wins, and a tie goes to the
    // requester that was not served last
    function automatic int pickGrant();
        if (req0_valid && req1_valid) return (lastServed == 0) ? 1 : 0;
        return req1_valid ? 1 : 0;
    endfunction

    function automatic logic randOp();
`ifdef SERIAL_SUB_EN
        return logic'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs are driven and outputs sampled just after the falling edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int id, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic op);
        heldA[id]  = a;
        heldB[id]  = b;
        heldOp[id] = op;
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    // Waits for the expected grant, follows one operation through ADD,
    // holds the response for 'hold' cycles, and then takes it
    task automatic serveOne(input int expId, input int hold);
        int waitCnt = 0;
        int lat = 1;
        logic [WIDTH:0] expSum;
        #1;
        while (!(req0_ready || req1_ready) && waitCnt < 40) begin
            tick();
            waitCnt++;
        end
        checkOutput("grant_seen", 32'(req0_ready | req1_ready), 32'd1);
        checkOutput("grant_id", 32'(req1_ready), 32'(expId));
        checkOutput("grant_onehot", 32'(req0_ready & req1_ready), 32'd0);
        expSum = refResult(heldA[expId], heldB[expId], heldOp[expId]);
        lastServed = expId;
        tick();
        if (expId == 0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
        checkOutput("ready_in_add", 32'(req0_ready | req1_ready), 32'd0);
        checkOutput("busy_in_add", 32'(busy), 32'd1);
        checkOutput("bitcnt_first", 32'(bit_cnt), 32'd0);
        checkOutput("fa_a_lsb", 32'(fa_a), 32'(heldA[expId][0]));
        checkOutput("fa_b_lsb", 32'(fa_b), 32'(heldB[expId][0] ^ heldOp[expId]));
        checkOutput("fa_cin_init", 32'(fa_cin), 32'(heldOp[expId]));
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(WIDTH + 1));
        checkOutput("rsp_sum", 32'(rsp_sum), 32'(expSum));
        checkOutput("rsp_id", 32'(rsp_id), 32'(expId));
        checkOutput("fa_quiet_done", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_sum", 32'(rsp_sum), 32'(expSum));
            checkOutput("hold_id", 32'(rsp_id), 32'(expId));
            checkOutput("hold_no_ready", 32'(req0_ready | req1_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("rsp_taken", 32'(rsp_valid), 32'd0);
        checkOutput("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int waitCnt;
        int staleSeen;
        reset = 1'b0;
        rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 1'b0;

        $display("[TB] reset state and contention from reset release");
        applyStimulus(0, 4'd3, 4'd5, 1'b0);
        applyStimulus(1, 4'd9, 4'd9, 1'b0);
        tick();
        tick();
        checkOutput("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("rst_bitcnt", 32'(bit_cnt), 32'd0);
        checkOutput("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        reset = 1'b1;
        lastServed = 1;
        serveOne(pickGrant(), 0);
        serveOne(pickGrant(), 0);

        $display("[TB] second simultaneous pair with backpressure");
        applyStimulus(0, 4'($urandom), 4'($urandom), 1'b0);
        applyStimulus(1, 4'($urandom), 4'($urandom), 1'b0);
        serveOne(pickGrant(), 5);
        checkOutput("req1_ready_after_rsp", 32'(req1_ready), 32'd1);
        serveOne(pickGrant(), 0);

        $display("[TB] directed single add and boundaries");
        applyStimulus(0, 4'b1100, 4'b0110, 1'b0);
        serveOne(pickGrant(), 0);
        applyStimulus(1, 4'b1111, 4'b1111, 1'b0);
        serveOne(pickGrant(), 1);
        applyStimulus(0, 4'b0000, 4'b0000, 1'b0);
        serveOne(pickGrant(), 0);
        applyStimulus(1, 4'b1111, 4'b0001, 1'b0);
        serveOne(pickGrant(), 0);

        $display("[TB] reset during ADD");
        applyStimulus(1, 4'b1111, 4'b0001, 1'b0);
        #1;
        waitCnt = 0;
        while (!req1_ready && waitCnt < 40) begin
            tick();
            waitCnt++;
        end
        checkOutput("mid_grant", 32'(req1_ready), 32'd1);
        tick();
        tick();
        tick();
        checkOutput("mid_bitcnt", 32'(bit_cnt), 32'd2);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_bitcnt", 32'(bit_cnt), 32'd0);
        checkOutput("mid_rst_id", 32'(rsp_id), 32'd0);
        checkOutput("mid_rst_sum", 32'(rsp_sum), 32'd0);
        checkOutput("mid_rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        checkOutput("mid_rst_ready", 32'(req1_ready), 32'd0);
        req1_valid = 1'b0;
        tick();
        reset = 1'b1;
        lastServed = 1;
        staleSeen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid) staleSeen++;
        end
        checkOutput("no_stale_rsp", 32'(staleSeen), 32'd0);
        applyStimulus(0, 4'b0101, 4'b0011, 1'b0);
        serveOne(pickGrant(), 1);

`ifdef SERIAL_SUB_EN
        $display("[TB] subtract option");
        applyStimulus(0, 4'b1100, 4'b0110, 1'b1);
        serveOne(pickGrant(), 0);
        applyStimulus(1, 4'b0110, 4'b1100, 1'b1);
        serveOne(pickGrant(), 0);
`endif

        $display("[TB] randomized traffic");
        for (int n = 0; n < 24; n++) begin
            if (!req0_valid && ($urandom_range(0, 1) == 1))
                applyStimulus(0, 4'($urandom), 4'($urandom), randOp());
            if (!req1_valid && ($urandom_range(0, 1) == 1))
                applyStimulus(1, 4'($urandom), 4'($urandom), randOp());
            if (!req0_valid && !req1_valid)
                applyStimulus(0, 4'($urandom), 4'($urandom), randOp());
            serveOne(pickGrant(), $urandom_range(0, 2));
        end
        while (req0_valid || req1_valid) serveOne(pickGrant(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/serial_add_scheduler.md
Name: serial_add_scheduler

Overview:
Sequencer and two-port arbiter that shares a single external combinational 1-bit full-adder cell (a, b, cin -> s, cout) between two requesters. It accepts a WIDTH-bit operand pair from the granted requester, feeds operands LSB-first through the cell one bit per clock, and carries between bits in an internal carry flop. It then returns the (WIDTH+1)-bit sum tagged with the requester ID over a valid/ready response port. It is the control layer placed in front of the serial-adder datapath.

Parameters:
WIDTH, 4, operand width in bits (>=2); bit counter width is clog2(WIDTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has operands
req0_ready  out  1  requester 0 accepted this cycle
req0_a  in  WIDTH  requester 0 operand A
req0_b  in  WIDTH  requester 0 operand B
req1_valid / req1_ready / req1_a / req1_b  as above, requester 1
fa_a  out  1  bit to full-adder cell, A
fa_b  out  1  bit to full-adder cell, B
fa_cin  out  1  carry into cell
fa_s  in  1  cell sum bit
fa_cout  in  1  cell carry out
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_id  out  1  requester that owns result
rsp_sum  out  WIDTH+1  {carry, sum}
busy  out  1  state != IDLE
bit_cnt  out  clog2(WIDTH)  current bit index in ADD

Behaviour:
- States: IDLE, ADD, DONE. Reset (reset=0, any time, async) -> IDLE; carry=0, bit_cnt=0, shift regs=0, rsp_sum=0, rsp_id=0, rsp_valid=0, rr pointer favours req0. req*_ready forced 0 while reset low. An in-flight operation is dropped; no response is produced.
- Arbitration (IDLE only): if one valid, grant it; if both valid, grant the one not served last (round-robin). reqN_ready = (state==IDLE) && reqN_valid && grantN. Combinational; at most one ready high.
- Accept edge (valid&&ready): latch a/b into shift regs, carry<=0, bit_cnt<=0, rsp_id<=granted index, pointer updated, state->ADD.
- ADD: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry. Each edge: a_sh/b_sh shift right, sum_sh shifts fa_s in at MSB end, carry<=fa_cout, bit_cnt++. On the edge with bit_cnt==WIDTH-1: rsp_sum<={fa_cout, fa_s, sum_sh upper WIDTH-1 bits}, rsp_valid<=1, state->DONE.
- Latency: rsp_valid rises exactly WIDTH clocks after the accept edge.
- DONE: rsp_sum/rsp_id held stable while rsp_valid && !rsp_ready. On rsp_valid&&rsp_ready, rsp_valid<=0 and state->IDLE. The next accept happens no earlier than the following cycle.
- Outside ADD: fa_a=fa_b=fa_cin=0, bit_cnt=0.
- Requests arriving during ADD/DONE see ready=0 and must hold valid/operands. No queuing.
- Overflow: no wrap. Carry is kept in rsp_sum[WIDTH]. Max 4-bit case 1111+1111 = 11110.

Optional Feature:
SERIAL_SUB_EN: adds inputs req0_op, req1_op (1 bit, 0=add, 1=sub), latched at accept. When op=1: fa_b = ~b_sh[0] and initial carry = 1, giving A-B in two's complement. rsp_sum[WIDTH] = 1 means no borrow (A>=B). Without the macro: the op ports do not exist and the block behaves as add-only.

Test Plan:
- Single add: req0 a=1100 b=0110 -> req0_ready 1 cycle; rsp_valid exactly 4 clocks later; rsp_sum=10010, rsp_id=0.
- Contention: req0 and req1 both valid from reset release (req0 3+5, req1 9+9) -> req0 served first, rsp 01000 id0; then req1, rsp 10010 id1. A further pair of simultaneous requests is granted to req0 (round-robin alternation).
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_sum, rsp_id stable; req1_valid held high sees ready=0 until the cycle after rsp handshake.
- Overflow/boundary: 1111+1111 -> 11110; 0000+0000 -> 00000; 1111+0001 -> 10000 (full carry ripple across all bits).
- Reset mid-ADD: pull reset low at bit_cnt=2 -> all outputs return to reset values immediately; after release no rsp_valid appears, and a new request completes normally.
- SERIAL_SUB_EN: op=1, 1100-0110 -> rsp_sum=10110; 0110-1100 -> 01010 (borrow).
